// File: rtl/hht_rd_sequencer.sv
// hht_rd_sequencer: walks a W-column (port 1) and the v-vector (port 2) in
// lock-step and streams registered {col, v, idx, last} beats to the MAC over
// valid/ready. The v index wraps modulo v_len so a short v-vector is reused
// across a long column. Addresses wrap silently modulo 2^AW.
module hht_rd_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic [AW-1:0] col_base,
    input  logic [AW-1:0] v_base,
    input  logic [LW-1:0] col_len,
    input  logic [LW-1:0] v_len,
    output logic [AW-1:0] addr1,
    output logic [AW-1:0] addr2,
    output logic          rd_en,
    input  logic [DW-1:0] dataIn1,
    input  logic [DW-1:0] dataIn2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_col,
    output logic [DW-1:0] out_v,
    output logic [LW-1:0] out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr1_q, addr1_d;
    logic [AW-1:0] addr2_q, addr2_d;
    logic [AW-1:0] v_base_q, v_base_d;
    logic [LW-1:0] col_len_q, col_len_d;
    logic [LW-1:0] v_len_q, v_len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] vidx_q, vidx_d;
    logic [DW-1:0] out_col_q, out_col_d;
    logic [DW-1:0] out_v_q, out_v_d;
    logic [LW-1:0] out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          slot_free;
    logic [LW-1:0] vidx_nxt;

    // Next-state and datapath: capture a beat whenever the output slot is free.
    always_comb begin
        // NOTE: every _d defaults to its _q (pulses to 0) before the case, so no path infers a latch.
        state_d     = state_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        v_base_d    = v_base_q;
        col_len_d   = col_len_q;
        v_len_d     = v_len_q;
        cnt_d       = cnt_q;
        vidx_d      = vidx_q;
        out_col_d   = out_col_q;
        out_v_d     = out_v_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        slot_free = !out_valid_q || out_ready;
        vidx_nxt  = (vidx_q == v_len_q - LW'(1)) ? '0 : vidx_q + LW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (start) begin
                    if (col_len == '0 || v_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        v_base_d  = v_base;
                        col_len_d = col_len;
                        v_len_d   = v_len;
                        addr1_d   = col_base;
                        addr2_d   = v_base;
                        cnt_d     = '0;
                        vidx_d    = '0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (slot_free) begin
                    out_col_d   = dataIn1;
                    out_v_d     = dataIn2;
                    out_idx_d   = cnt_q;
                    out_last_d  = (cnt_q == col_len_q - LW'(1));
                    out_valid_d = 1'b1;
                    addr1_d     = addr1_q + AW'(1);
                    cnt_d       = cnt_q + LW'(1);
                    vidx_d      = vidx_nxt;
                    addr2_d     = v_base_q + AW'(vidx_nxt);
                    if (cnt_q == col_len_q - LW'(1)) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, address and beat registers; async reset clears everything.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            addr1_q     <= '0;
            addr2_q     <= '0;
            v_base_q    <= '0;
            col_len_q   <= '0;
            v_len_q     <= '0;
            cnt_q       <= '0;
            vidx_q      <= '0;
            out_col_q   <= '0;
            out_v_q     <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            state_q     <= state_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            v_base_q    <= v_base_d;
            col_len_q   <= col_len_d;
            v_len_q     <= v_len_d;
            cnt_q       <= cnt_d;
            vidx_q      <= vidx_d;
            out_col_q   <= out_col_d;
            out_v_q     <= out_v_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign addr1     = addr1_q;
    assign addr2     = addr2_q;
    assign rd_en     = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign out_v     = out_v_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hht_rd_sequencer.sv
// Bench for hht_rd_sequencer: table of passes checked against a reference
// model that derives each expected beat directly from the memory image.
module tb_hht_rd_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] col_base = '0, v_base = '0, col_len = '0, v_len = '0;
    logic [31:0] addr1, addr2, dataIn1, dataIn2, out_col, out_v, out_idx;
    logic        rd_en, out_valid, out_last, busy, done, err;
    logic        out_ready = 1'b1;

    logic [31:0] mem [1024];

    assign dataIn1 = mem[addr1[9:0]];
    assign dataIn2 = mem[addr2[9:0]];

    hht_rd_sequencer #(.AW(32), .DW(32), .LW(32)) dut (
        .Clk(Clk), .Rst(Rst), .start(start),
        .col_base(col_base), .v_base(v_base), .col_len(col_len), .v_len(v_len),
        .addr1(addr1), .addr2(addr2), .rd_en(rd_en),
        .dataIn1(dataIn1), .dataIn2(dataIn2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_v(out_v), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] col;
        logic [31:0] v;
        logic [31:0] idx;
        logic        last;
    } beat_t;

    // mode: 0 ready always 1, 1 random ready, 2 three-cycle stall at beat 5,
    //       3 ready 1 with a foreign start pulse during RUN
    typedef struct {
        logic [31:0] cb;
        logic [31:0] vb;
        logic [31:0] cl;
        logic [31:0] vl;
        int          mode;
        int          exp_done_t;
        logic        exp_err;
    } pass_t;

    beat_t exp_q[$];
    int    t, first_beat_t, done_t, done_cnt, err_cnt, beats_seen;

    // Reference: beat k reads column word cb+k and v word vb+(k mod vl).
    function automatic beat_t ref_beat(input logic [31:0] cb, input logic [31:0] vb,
                                       input logic [31:0] cl, input logic [31:0] vl,
                                       input logic [31:0] k);
        beat_t       b;
        logic [31:0] a1, a2;
        a1     = cb + k;
        a2     = vb + (k % vl);
        b.col  = mem[a1[9:0]];
        b.v    = mem[a2[9:0]];
        b.idx  = k;
        b.last = (k == cl - 1);
        return b;
    endfunction

    // Sample at the negedge, then advance one clock.
    task automatic tick();
        beat_t e;
        if (out_valid && out_ready) begin
            beats_seen++;
            if (beats_seen == 1) first_beat_t = t;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_beat: got idx %0d expected no beat", out_idx);
            end else begin
                e = exp_q.pop_front();
                check("beat", {out_col, out_v, out_idx, out_last}, {e.col, e.v, e.idx, e.last});
            end
        end
        if (done) begin
            done_cnt++;
            done_t = t;
        end
        if (err) err_cnt++;
        @(posedge Clk);
        @(negedge Clk);
        t++;
    endtask

    task automatic load_expect(input pass_t p);
        exp_q.delete();
        t = 0; beats_seen = 0; done_cnt = 0; err_cnt = 0; done_t = -1; first_beat_t = -1;
        if (!p.exp_err)
            for (int k = 0; k < int'(p.cl); k++) exp_q.push_back(ref_beat(p.cb, p.vb, p.cl, p.vl, k));
        col_base = p.cb; v_base = p.vb; col_len = p.cl; v_len = p.vl;
    endtask

    task automatic run_pass(input pass_t p);
        int          budget;
        int          stalls;
        logic [31:0] a;
        load_expect(p);
        budget    = int'(p.cl) * 8 + 40;
        stalls    = 3;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (p.exp_err) begin
            repeat (3) tick();
            check("err_pulse_count", err_cnt, 1);
            check("err_busy", busy, 1'b0);
            check("err_no_beats", beats_seen, 0);
            check("err_no_done", done_cnt, 0);
            return;
        end
        while (done_cnt == 0 && t < budget) begin
            start = 1'b0;
            case (p.mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && out_idx == 5 && stalls > 0) begin
                        if (stalls < 3) begin
                            // addresses run one element ahead of the held beat
                            a = p.cb + 5;
                            check("stall_idx", out_idx, 5);
                            check("stall_col", out_col, mem[a[9:0]]);
                            check("stall_addr1", addr1, p.cb + 6);
                        end
                        out_ready = 1'b0;
                        stalls--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                3: begin
                    out_ready = 1'b1;
                    if (t == 10) begin
                        start    = 1'b1;
                        col_base = p.cb + 100;
                        v_base   = p.vb + 50;
                        col_len  = 3;
                        v_len    = 2;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("done_count", done_cnt, 1);
        check("beats_left", exp_q.size(), 0);
        check("beats_seen", beats_seen, p.cl);
        check("busy_after_done", busy, 1'b0);
        if (p.exp_done_t >= 0) begin
            check("done_time", done_t, p.exp_done_t);
            check("first_beat_time", first_beat_t, 2);
        end
    endtask

    pass_t tbl[10];

    initial begin
        pass_t       p;
        int          guard;
        logic [31:0] wrap_base;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[180] = 32'd2;  mem[2] = 32'd74;
        mem[181] = 32'd6;  mem[3] = 32'd10;
        mem[256] = 32'd8;

        tbl[0] = '{180, 2, 77, 16, 0, 79, 1'b0};
        tbl[1] = '{180, 2, 77, 16, 2, 82, 1'b0};
        tbl[2] = '{5, 5, 0, 4, 0, -1, 1'b1};
        tbl[3] = '{5, 5, 4, 0, 0, -1, 1'b1};
        tbl[4] = '{300, 400, 1, 1, 0, 3, 1'b0};
        tbl[5] = '{300, 400, 1, 1, 0, 3, 1'b0};
        tbl[6] = '{500, 20, 40, 3, 3, 42, 1'b0};
        tbl[7] = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 10, 5, 0, 12, 1'b0};
        tbl[8] = '{600, 700, 25, 1, 1, -1, 1'b0};
        tbl[9] = '{50, 900, 33, 7, 1, -1, 1'b0};

        // asynchronous reset: outputs must be zero without any clock edge
        #2 Rst = 1'b0;
        #1 check("reset_state",
                 {addr1, addr2, out_col, out_v, out_idx, rd_en, out_valid, out_last, busy, done, err}, '0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 10; i++) run_pass(tbl[i]);

        // randomized passes, some with addresses wrapping past 2^32
        for (int r = 0; r < 8; r++) begin
            wrap_base = 32'hFFFF_FFFF - $urandom_range(0, 20);
            p.cb = (r % 2 == 0) ? wrap_base : $urandom;
            p.vb = $urandom;
            p.cl = $urandom_range(1, 30);
            p.vl = $urandom_range(1, 8);
            p.mode = (r % 3 == 0) ? 0 : 1;
            p.exp_done_t = (p.mode == 0) ? int'(p.cl) + 2 : -1;
            p.exp_err = 1'b0;
            run_pass(p);
        end

        // reset in the middle of a pass at beat 30
        p = tbl[0];
        load_expect(p);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(out_valid && out_idx == 30) && guard < 100) begin
            tick();
            guard++;
        end
        check("reached_beat30", out_idx, 30);
        Rst = 1'b0;
        #1 check("midpass_reset",
                 {addr1, addr2, out_col, out_v, out_idx, rd_en, out_valid, out_last, busy, done, err}, '0);
        exp_q.delete();
        @(negedge Clk);
        Rst = 1'b1;
        done_cnt = 0;
        repeat (3) tick();
        check("no_done_after_reset", done_cnt, 0);
        run_pass(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
